// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU bitstream path: fetcher FSM states and block geometry.
package pmu_pkg;

    localparam int ADDR_WIDTH_DEF      = 8;
    localparam int DATA_LENGTH_DEF     = 32;
    localparam int AES_DATA_LENGTH_DEF = 128;
    localparam int WORDS_PER_BLOCK     = AES_DATA_LENGTH_DEF / DATA_LENGTH_DEF;
    localparam int LOAD_CYCLES         = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_FETCH,
        ST_WAIT,
        ST_PRESENT,
        ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/bitstream_fetcher_blk_assembler.sv
// Block assembly register: each incoming word lands in the slot selected by its word index,
// word 0 in the most significant slot.
module blk_assembler
    import pmu_pkg::*;
#(
    parameter int WORD_W = DATA_LENGTH_DEF,
    parameter int WORDS  = WORDS_PER_BLOCK,
    localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_load,
    input  logic [IDXW-1:0]         i_idx,
    input  logic [WORD_W-1:0]       i_word,
    output logic [WORD_W*WORDS-1:0] o_blk
);

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_slot
            logic [WORD_W-1:0] r_slot;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_slot <= '0;
                end else if (i_clear) begin
                    r_slot <= '0;
                end else if (i_load && (i_idx == IDXW'(gi))) begin
                    r_slot <= i_word;
                end
            end

            assign o_blk[(WORDS-1-gi)*WORD_W +: WORD_W] = r_slot;
        end
    endgenerate

endmodule

// File: rtl/bitstream_fetcher.sv
// Reads the bootloader record, streams the bitstream from configuration memory word by word
// and hands 128-bit blocks to the AES core over a valid/ready handshake.
module bitstream_fetcher
    import pmu_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int DATA_LENGTH     = DATA_LENGTH_DEF,
    parameter int AES_DATA_LENGTH = AES_DATA_LENGTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [ADDR_WIDTH-1:0]      bl_addr_i,
    input  logic [DATA_LENGTH-1:0]     bl_len_i,
    output logic                       mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]      mem_addr_o,
    input  logic [DATA_LENGTH-1:0]     mem_data_i,
    output logic [AES_DATA_LENGTH-1:0] blk_data_o,
    output logic                       blk_valid_o,
    input  logic                       blk_ready_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int WPB = AES_DATA_LENGTH / DATA_LENGTH;
    localparam int WIW = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int EW  = ADDR_WIDTH + DATA_LENGTH + 2;

    fetch_state_t           r_state;
    logic [LCW-1:0]         r_load_cnt;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [DATA_LENGTH-1:0] r_nblk;
    logic [DATA_LENGTH-1:0] r_blk_idx;
    logic [WIW-1:0]         r_word_idx;
    logic                   r_mem_rd_en;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic                   r_cap_en;
    logic [WIW-1:0]         r_cap_idx;
    logic                   r_blk_valid;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic                       w_start_accept;
    logic [EW-1:0]              w_end;
    logic [EW-1:0]              w_limit;
    logic                       w_overflow;
    logic                       w_last_word;
    logic                       w_last_blk;
    logic [AES_DATA_LENGTH-1:0] w_blk_data;

    assign w_start_accept = (r_state == ST_IDLE) && start_i;
    // Range check in a width that cannot wrap for any base/length combination.
    assign w_end       = EW'(r_base) + (EW'(r_nblk) * EW'(WPB));
    assign w_limit     = EW'(1) << ADDR_WIDTH;
    assign w_overflow  = (w_end > w_limit);
    assign w_last_word = (r_word_idx == WIW'(WPB - 1));
    assign w_last_blk  = (r_blk_idx == (r_nblk - DATA_LENGTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_load_cnt  <= '0;
            r_base      <= '0;
            r_nblk      <= '0;
            r_blk_idx   <= '0;
            r_word_idx  <= '0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_cap_en    <= 1'b0;
            r_cap_idx   <= '0;
            r_blk_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Memory data returns one cycle after the strobe, so the capture lags the read.
            r_cap_en  <= r_mem_rd_en;
            r_cap_idx <= r_word_idx;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state    <= ST_LOAD;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_load_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (r_load_cnt == LCW'(LOAD_CYCLES - 1)) begin
                        r_base  <= bl_addr_i;
                        r_nblk  <= bl_len_i;
                        r_state <= ST_CHECK;
                    end else begin
                        r_load_cnt <= r_load_cnt + LCW'(1);
                    end
                end
                ST_CHECK: begin
                    if (r_nblk == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (w_overflow) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= ST_FETCH;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= r_base;
                        r_word_idx  <= '0;
                        r_blk_idx   <= '0;
                    end
                end
                ST_FETCH: begin
                    if (w_last_word) begin
                        r_mem_rd_en <= 1'b0;
                        r_state     <= ST_WAIT;
                    end else begin
                        r_word_idx <= r_word_idx + WIW'(1);
                        r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
                    end
                end
                ST_WAIT: begin
                    r_state     <= ST_PRESENT;
                    r_blk_valid <= 1'b1;
                end
                ST_PRESENT: begin
                    if (blk_ready_i) begin
                        r_blk_valid <= 1'b0;
                        if (w_last_blk) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // Blocks are contiguous, so the next address follows the last read.
                            r_blk_idx   <= r_blk_idx + DATA_LENGTH'(1);
                            r_state     <= ST_FETCH;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(1);
                            r_word_idx  <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_mem_rd_en <= 1'b0;
                    r_blk_valid <= 1'b0;
                end
            endcase
        end
    end

    blk_assembler #(
        .WORD_W (DATA_LENGTH),
        .WORDS  (WPB)
    ) u_blk_assembler (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start_accept),
        .i_load  (r_cap_en),
        .i_idx   (r_cap_idx),
        .i_word  (mem_data_i),
        .o_blk   (w_blk_data)
    );

    assign mem_rd_en_o = r_mem_rd_en;
    assign mem_addr_o  = r_mem_addr;
    assign blk_data_o  = w_blk_data;
    assign blk_valid_o = r_blk_valid;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule
